// File: rtl/stbxfer_sched_pkg.sv
// stbxfer_sched_pkg
//   Shared types and constants for the strobe-transfer scheduler.
//   - state_t      : scheduler FSM states
//   - DEF_HOLDOFF  : holdoff value loaded at reset
//   - tag_width()  : minimum tag width able to index n requesters
package stbxfer_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEF_HOLDOFF = 8;

    function automatic int tag_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stbxfer_sched_if.sv
// stbxfer_sched_if
//   Bundles the requester/config side and the transfer-channel side of the
//   scheduler. Signal names keep their direction prefixes as seen from the
//   scheduler.
//   Ports (slave = scheduler view):
//     i_req         in   NREQ    single-cycle event pulses
//     i_cfg_wr      in   1       load i_cfg_holdoff
//     i_cfg_holdoff in   LGHOLD  new holdoff value
//     i_ovf_clr     in   NREQ    clear sticky overflow flags
//     o_stb         out  1       one-cycle strobe to the channel
//     o_tag         out  TAGW    index of the granted requester
//     o_busy        out  1       holdoff in progress
//     o_pending     out  NREQ    queued, ungranted events
//     o_overflow    out  NREQ    sticky coalesce flags
interface stbxfer_sched_if #(
    parameter int NREQ   = 4,
    parameter int TAGW   = 2,
    parameter int LGHOLD = 4
);
    logic [NREQ-1:0]   i_req;
    logic              i_cfg_wr;
    logic [LGHOLD-1:0] i_cfg_holdoff;
    logic [NREQ-1:0]   i_ovf_clr;
    logic              o_stb;
    logic [TAGW-1:0]   o_tag;
    logic              o_busy;
    logic [NREQ-1:0]   o_pending;
    logic [NREQ-1:0]   o_overflow;

    modport master (
        output i_req, i_cfg_wr, i_cfg_holdoff, i_ovf_clr,
        input  o_stb, o_tag, o_busy, o_pending, o_overflow
    );

    modport slave (
        input  i_req, i_cfg_wr, i_cfg_holdoff, i_ovf_clr,
        output o_stb, o_tag, o_busy, o_pending, o_overflow
    );
endinterface

// File: rtl/stbxfer_rrarb.sv
// stbxfer_rrarb
//   Combinational round-robin priority search. Finds the first set bit of
//   pending starting at (last_grant+1) mod NREQ, wrapping around.
//   Ports:
//     pending     in   NREQ  request vector
//     last_grant  in   TAGW  most recently granted index
//     grant       out  TAGW  selected index (0 when valid is low)
//     valid       out  1     at least one pending bit was found
module stbxfer_rrarb
    import stbxfer_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int TAGW = 2
) (
    input  logic [NREQ-1:0] pending,
    input  logic [TAGW-1:0] last_grant,
    output logic [TAGW-1:0] grant,
    output logic            valid
);

    // Two passes with constant indices: first the indices above last_grant,
    // then wrap and take anything from 0 upward.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!valid && pending[i] && (i > int'(last_grant))) begin
                valid = 1'b1;
                grant = TAGW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!valid && pending[i]) begin
                valid = 1'b1;
                grant = TAGW'(i);
            end
        end
    end

endmodule

// File: rtl/stbxfer_sched.sv
// stbxfer_sched
//   Shares one cross-domain strobe-transfer channel among NREQ requesters.
//   Events are queued in a pending vector, arbitrated round-robin, and issued
//   one strobe at a time, each followed by a programmable holdoff that covers
//   the channel round trip. o_tag stays stable from one grant to the next.
//   Optional build macro: STBXFER_SCHED_OVERFLOW_EN adds sticky per-requester
//   coalesce flags; without it o_overflow is 0 and i_ovf_clr is ignored.
//   Ports:
//     i_clk      in   1   source-domain clock
//     i_reset_n  in   1   asynchronous active-low reset
//     bus        slave modport of stbxfer_sched_if (requests, config,
//                strobe/tag, status)
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no strobe in flight; grants immediately when pending != 0
//   HOLD  | strobe issued in first cycle; counts holdoff down to 0
module stbxfer_sched #(
    parameter int NREQ        = 4,
    parameter int TAGW        = stbxfer_sched_pkg::tag_width(NREQ),
    parameter int LGHOLD      = 4,
    parameter int DEF_HOLDOFF = stbxfer_sched_pkg::DEF_HOLDOFF
) (
    input logic             i_clk,
    input logic             i_reset_n,
    stbxfer_sched_if.slave  bus
);
    import stbxfer_sched_pkg::*;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   pending_q, pending_d;
    logic [NREQ-1:0]   gnt_oh;
    logic [TAGW-1:0]   last_grant_q, last_grant_d;
    logic [TAGW-1:0]   tag_q, tag_d;
    logic              stb_q, stb_d;
    logic [LGHOLD-1:0] holdoff_q;
    logic [LGHOLD-1:0] cnt_q, cnt_d;
    logic [TAGW-1:0]   arb_idx;
    logic              arb_vld;
    logic              grant_en;

    stbxfer_rrarb #(
        .NREQ (NREQ),
        .TAGW (TAGW)
    ) u_arb (
        .pending    (pending_q),
        .last_grant (last_grant_q),
        .grant      (arb_idx),
        .valid      (arb_vld)
    );

    assign grant_en = (state_q == IDLE) && arb_vld;
    assign gnt_oh   = grant_en ? ({{(NREQ-1){1'b0}}, 1'b1} << arb_idx) : '0;

    // A request arriving in its own grant cycle survives: clear first, then set.
    assign pending_d = (pending_q & ~gnt_oh) | bus.i_req;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            last_grant_q <= TAGW'(NREQ - 1);
            tag_q        <= '0;
            stb_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            last_grant_q <= last_grant_d;
            tag_q        <= tag_d;
            stb_q        <= stb_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        stb_d        = 1'b0;
        cnt_d        = cnt_q;
        tag_d        = tag_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    state_d      = HOLD;
                    stb_d        = 1'b1;
                    tag_d        = arb_idx;
                    last_grant_d = arb_idx;
                    cnt_d        = holdoff_q;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - LGHOLD'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The running count was captured at grant time, so a write here only
    // affects the next grant.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            holdoff_q <= LGHOLD'(DEF_HOLDOFF);
        end else if (bus.i_cfg_wr) begin
            holdoff_q <= bus.i_cfg_holdoff;
        end
    end

`ifdef STBXFER_SCHED_OVERFLOW_EN
    logic [NREQ-1:0] overflow_q;

    // Set on a request that merges into an already-pending, ungranted event;
    // set takes priority over a same-cycle clear.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            overflow_q <= '0;
        end else begin
            overflow_q <= (overflow_q & ~bus.i_ovf_clr)
                        | (bus.i_req & pending_q & ~gnt_oh);
        end
    end

    assign bus.o_overflow = overflow_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ^bus.i_ovf_clr;
    assign bus.o_overflow = '0;
`endif

    assign bus.o_stb     = stb_q;
    assign bus.o_tag     = tag_q;
    assign bus.o_busy    = (state_q == HOLD);
    assign bus.o_pending = pending_q;

endmodule

// File: tb/tb_stbxfer_sched.sv
module tb_stbxfer_sched;
    localparam int NREQ   = 4;
    localparam int TAGW   = 2;
    localparam int LGHOLD = 4;
`ifdef STBXFER_SCHED_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic i_clk     = 1'b0;
    logic i_reset_n = 1'b0;
    int   checks    = 0;
    int   failures  = 0;

    stbxfer_sched_if #(.NREQ(NREQ), .TAGW(TAGW), .LGHOLD(LGHOLD)) bus ();

    stbxfer_sched #(
        .NREQ        (NREQ),
        .TAGW        (TAGW),
        .LGHOLD      (LGHOLD),
        .DEF_HOLDOFF (8)
    ) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .bus       (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset_n         = 1'b0;
        bus.i_req         = '0;
        bus.i_cfg_wr      = 1'b0;
        bus.i_cfg_holdoff = '0;
        bus.i_ovf_clr     = '0;
        step();
        step();
        i_reset_n = 1'b1;
    endtask

    // Leaves the caller at the start of "cycle 0".
    task automatic set_holdoff(input logic [3:0] h);
        bus.i_cfg_wr      = 1'b1;
        bus.i_cfg_holdoff = h;
        step();
        bus.i_cfg_wr      = 1'b0;
    endtask

    initial begin
        int          n;
        int          k;
        logic [1:0]  last_tag;
        logic [1:0]  ftags [3];

        // ---------------- reset values
        do_reset();
        i_reset_n = 1'b0;
        #1;
        check("rst_stb",  bus.o_stb,      0);
        check("rst_tag",  bus.o_tag,      0);
        check("rst_busy", bus.o_busy,     0);
        check("rst_pend", bus.o_pending,  0);
        check("rst_ovf",  bus.o_overflow, 0);
        i_reset_n = 1'b1;

        // ---------------- single event, holdoff 3
        do_reset();
        set_holdoff(4'd3);
        bus.i_req = 4'b0100;
        step();
        bus.i_req = '0;
        check("se_c1_stb",  bus.o_stb,     0);
        check("se_c1_pend", bus.o_pending, 4'b0100);
        step();
        check("se_c2_stb",  bus.o_stb,     1);
        check("se_c2_tag",  bus.o_tag,     2);
        check("se_c2_busy", bus.o_busy,    1);
        check("se_c2_pend", bus.o_pending, 0);
        for (int c = 3; c <= 6; c++) begin
            step();
            check("se_stb",  bus.o_stb,  0);
            check("se_busy", bus.o_busy, (c <= 5) ? 1 : 0);
        end
        check("se_tag_hold", bus.o_tag, 2);

        // ---------------- all requesters, holdoff 2
        do_reset();
        set_holdoff(4'd2);
        bus.i_req = 4'b1111;
        step();
        bus.i_req = '0;
        for (int c = 1; c <= 17; c++) begin
            if (c == 1) check("all_c1_pend", bus.o_pending, 4'b1111);
            if (c == 2 || c == 6 || c == 10 || c == 14) begin
                k = (c - 2) / 4;
                check("all_stb",  bus.o_stb,     1);
                check("all_tag",  bus.o_tag,     k);
                check("all_pend", bus.o_pending, (32'hF << (k + 1)) & 32'hF);
            end else begin
                check("all_nostb", bus.o_stb, 0);
            end
            step();
        end

        // ---------------- fairness: req0 every cycle, req3 once
        do_reset();
        set_holdoff(4'd2);
        n = 0;
        ftags[0] = 2'd1; ftags[1] = 2'd1; ftags[2] = 2'd1;
        bus.i_req = 4'b1001;
        step();
        bus.i_req = 4'b0001;
        for (int c = 1; c < 40 && n < 3; c++) begin
            if (bus.o_stb) begin
                ftags[n] = bus.o_tag;
                n++;
            end
            step();
        end
        bus.i_req = '0;
        check("fair_count", n, 3);
        check("fair_tag0", ftags[0], 0);
        check("fair_tag1", ftags[1], 3);
        check("fair_tag2", ftags[2], 0);

        // ---------------- coalesce while busy on requester 0
        do_reset();
        set_holdoff(4'd3);
        bus.i_req = 4'b0001;
        step();
        bus.i_req = '0;
        step();
        check("co_c2_stb", bus.o_stb, 1);
        check("co_c2_tag", bus.o_tag, 0);
        bus.i_req = 4'b0010;
        step();
        check("co_c3_pend", bus.o_pending, 4'b0010);
        step();
        bus.i_req = '0;
        check("co_c4_pend", bus.o_pending, 4'b0010);
        check("co_c4_ovf",  bus.o_overflow, OVF_EN ? 32'h2 : 32'h0);
        n = 0;
        last_tag = '0;
        for (int c = 4; c <= 24; c++) begin
            if (bus.o_stb) begin
                n++;
                last_tag = bus.o_tag;
            end
            step();
        end
        check("co_nstb",  n,               1);
        check("co_tag",   last_tag,        1);
        check("co_pend",  bus.o_pending,   0);
        check("co_ovf_sticky", bus.o_overflow, OVF_EN ? 32'h2 : 32'h0);
        bus.i_ovf_clr = 4'b0010;
        step();
        bus.i_ovf_clr = '0;
        check("co_ovf_clr", bus.o_overflow, 0);

        // ---------------- request in its own grant cycle
        do_reset();
        set_holdoff(4'd3);
        bus.i_req = 4'b0100;
        step();
        check("sc_c1_busy", bus.o_busy,    0);
        check("sc_c1_pend", bus.o_pending, 4'b0100);
        step();
        bus.i_req = '0;
        check("sc_c2_stb",  bus.o_stb,      1);
        check("sc_c2_tag",  bus.o_tag,      2);
        check("sc_c2_pend", bus.o_pending,  4'b0100);
        check("sc_c2_ovf",  bus.o_overflow, 0);
        for (int c = 3; c <= 8; c++) begin
            step();
            check("sc_stb", bus.o_stb, (c == 7) ? 1 : 0);
            if (c == 7) check("sc_tag", bus.o_tag, 2);
        end
        check("sc_pend_end", bus.o_pending, 0);

        // ---------------- async reset mid-HOLD, default holdoff
        do_reset();
        bus.i_req = 4'b0001;
        step();
        bus.i_req = '0;
        step();
        check("rh_c2_stb", bus.o_stb, 1);
        step();
        bus.i_req = 4'b1010;
        step();
        bus.i_req = '0;
        check("rh_pend", bus.o_pending, 4'b1010);
        check("rh_busy", bus.o_busy,    1);
        i_reset_n = 1'b0;
        #1;
        check("rh_rst_stb",  bus.o_stb,     0);
        check("rh_rst_busy", bus.o_busy,    0);
        check("rh_rst_pend", bus.o_pending, 0);
        step();
        i_reset_n = 1'b1;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (bus.o_stb) n++;
        end
        check("rh_no_stb", n, 0);
        bus.i_req = 4'b1001;
        step();
        bus.i_req = '0;
        step();
        check("rh_new_stb", bus.o_stb, 1);
        check("rh_new_tag", bus.o_tag, 0);
        for (int c = 3; c <= 11; c++) begin
            step();
            check("rh_busy_len", bus.o_busy, (c <= 10) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stbxfer_sched.md
Name: stbxfer_sched

Overview:
- Single-clock scheduler that shares one cross-domain strobe-transfer channel among NREQ source-domain event requesters (frame start, new FFT line, palette update, ...).
- The transfer channel merges strobes issued while a prior strobe is still in its round trip. This block queues events, arbitrates round-robin, and issues one strobe at a time.
- Each strobe carries a tag that stays stable for the whole holdoff. After each strobe, the block enforces a programmable holdoff that covers the channel round trip.

Parameters:
- NREQ, 4, number of requesters (2..16).
- TAGW, 2, tag width; must satisfy 2**TAGW >= NREQ.
- LGHOLD, 4, width of the holdoff counter.
- DEF_HOLDOFF, 8, holdoff value loaded at reset.

Ports:
- i_clk  in  1  source-domain clock
- i_reset_n  in  1  asynchronous active-low reset
- i_req  in  NREQ  per-requester single-cycle event pulses
- i_cfg_wr  in  1  load i_cfg_holdoff into the holdoff register
- i_cfg_holdoff  in  LGHOLD  new holdoff value
- i_ovf_clr  in  NREQ  clear overflow flags (used only with the optional feature)
- o_stb  out  1  strobe to the transfer channel, one cycle wide
- o_tag  out  TAGW  index of the granted requester; held until the next grant
- o_busy  out  1  high while in HOLD
- o_pending  out  NREQ  queued, ungranted events
- o_overflow  out  NREQ  sticky coalesce flags (used only with the optional feature)

Behaviour:
- Reset (async, i_reset_n low):
  - state=IDLE, o_stb=0, o_tag=0, pending=0, overflow=0.
  - holdoff=DEF_HOLDOFF; last_grant=NREQ-1, so requester 0 has first priority.
  - Reset mid-HOLD drops all pending events; no strobe is emitted after release.
- Pending set/clear:
  - pending[k] is set on i_req[k] and cleared on grant of k.
  - If i_req[k] arrives in the same cycle that k is granted, pending[k] stays set, so the new event is kept.
  - If i_req[k] arrives while pending[k] is already set, the two events coalesce into one.
- IDLE:
  - If pending != 0, grant the first set bit searching from (last_grant+1) mod NREQ upward, with wrap.
  - Register o_stb=1, o_tag=grant, last_grant=grant, cnt=holdoff; go to HOLD.
  - If pending == 0, stay in IDLE with o_stb=0.
- HOLD:
  - o_stb=0 after its first cycle.
  - If cnt==0, go to IDLE; otherwise cnt<=cnt-1.
  - HOLD lasts holdoff+1 cycles, starting in the o_stb cycle.
- Latency: i_req sampled at edge N, into an idle block, gives o_stb high during cycle N+2.
- Strobe spacing: minimum o_stb spacing is holdoff+2 cycles. Holdoff 0 is legal and gives spacing 2.
- Configuration: i_cfg_wr takes effect for the next grant only; the running count is unaffected.
- o_busy = (state==HOLD). o_pending is the registered pending vector.
- o_tag changes only at a grant. The destination side samples the tag on its strobe, so holdoff must exceed the round trip; this requirement belongs to the integrator.

Optional Feature:
- Macro STBXFER_SCHED_OVERFLOW_EN.
- Defined: overflow[k] sets when i_req[k] arrives while pending[k]=1 and k is not being granted in that cycle. i_ovf_clr[k] clears overflow[k]. If set and clear arrive in the same cycle, set wins.
- Undefined: o_overflow is tied to 0 and i_ovf_clr is ignored; no overflow flops are built.

Decomposition:
- Package stbxfer_sched_pkg holds:
  - state enum {IDLE, HOLD};
  - clog2-based tag-width helper;
  - DEF_HOLDOFF default constant.
- One sub-module, stbxfer_rrarb: combinational round-robin priority search. Inputs are pending and last_grant; outputs are grant index and a valid flag. The FSM, counter and flags stay in the top level.

Test Plan:
- Single event: after reset, holdoff=3; i_req=4'b0100 at cycle 0 -> o_stb cycle 2, o_tag=2, o_busy cycles 2-5, idle at cycle 6.
- All requesters: holdoff=2; i_req=4'b1111 at cycle 0 -> o_stb at cycles 2,6,10,14 with tags 0,1,2,3; o_pending empties one bit per grant.
- Fairness: requester 0 pulses every cycle, requester 3 pulses once -> 3 is granted within 2 strobes; tags alternate 0,3,0.
- Coalesce: i_req[1] pulsed at cycles 0 and 1 while busy on another grant -> exactly one strobe with tag 1. With the macro defined, o_overflow[1]=1 until i_ovf_clr[1].
- Same-cycle request and grant: i_req[2] re-pulsed in k=2's grant cycle -> second strobe with tag 2 after holdoff+2 cycles.
- Async reset mid-HOLD with pending=4'b1010 -> o_stb, o_busy and o_pending go 0 immediately; no strobe after release; holdoff returns to 8; the first new grant favours requester 0.
